// File: rtl/fdivsqrt_result_hold.sv
// ============================================================================
// Module      : fdivsqrt_result_hold
// Description : One-entry retire buffer behind the divide/sqrt FSM. Captures
//               result, flags and measured latency on the rising edge of done
//               and hands them to writeback with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fdivsqrt_result_hold #(
  parameter int QW   = 64,
  parameter int FLW  = 5,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushM,
  input  logic            StartE,
  input  logic            DoneE,
  input  logic            SpecialCaseM,
  input  logic [QW-1:0]   SpecialResM,
  input  logic [QW-1:0]   QuotientM,
  input  logic [FLW-1:0]  FlagsM,
  input  logic            WbReadyW,
  output logic            ResValidW,
  output logic [QW-1:0]   ResultW,
  output logic [FLW-1:0]  FlagsW,
  output logic [CNTW-1:0] LatencyW,
  output logic            HoldFullE
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;
  logic            done_q, done_d;
  logic            run_q, run_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [QW-1:0]   result_q, result_d;
  logic [FLW-1:0]  flags_q, flags_d;
  logic [CNTW-1:0] latency_q, latency_d;

  logic            done_rise;
  logic            capture;
  logic [CNTW-1:0] cnt_inc;

  assign done_rise = DoneE & ~done_q;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // A held result can only be replaced when writeback drains it in the same cycle.
  assign capture = done_rise & ~FlushM & ((state_q == EMPTY) | WbReadyW);

  always_comb begin
    state_d   = state_q;
    done_d    = DoneE;
    run_d     = run_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    flags_d   = flags_q;
    latency_d = latency_q;

    if (StartE) begin
      cnt_d = CNT_ONE;
      run_d = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_inc;
      if (done_rise) begin
        run_d = 1'b0;
      end
    end

    case (state_q)
      EMPTY: if (done_rise) state_d = FULL;
      FULL:  if (WbReadyW && !done_rise) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (capture) begin
      result_d  = SpecialCaseM ? SpecialResM : QuotientM;
      flags_d   = FlagsM;
      latency_d = cnt_inc;
    end

    if (FlushM) begin
      state_d = EMPTY;
      run_d   = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      done_q    <= 1'b0;
      run_q     <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      latency_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      latency_q <= latency_d;
    end
  end

  assign ResValidW = (state_q == FULL);
  assign HoldFullE = (state_q == FULL);
  assign ResultW   = result_q;
  assign FlagsW    = flags_q;
  assign LatencyW  = latency_q;

endmodule

`default_nettype wire

// File: tb/tb_fdivsqrt_result_hold.sv
// ============================================================================
// Module      : tb_fdivsqrt_result_hold
// Description : Directed bench for the divide/sqrt result holding stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fdivsqrt_result_hold;

  logic        clk = 1'b0;
  logic        reset;
  logic        FlushM, StartE, DoneE, SpecialCaseM, WbReadyW;
  logic [63:0] SpecialResM, QuotientM;
  logic [4:0]  FlagsM;

  logic        ResValidW, HoldFullE;
  logic [63:0] ResultW;
  logic [4:0]  FlagsW;
  logic [7:0]  LatencyW;

  logic        ResValidW4, HoldFullE4;
  logic [63:0] ResultW4;
  logic [4:0]  FlagsW4;
  logic [3:0]  LatencyW4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fdivsqrt_result_hold u_dut (
    .clk(clk), .reset(reset), .FlushM(FlushM), .StartE(StartE), .DoneE(DoneE),
    .SpecialCaseM(SpecialCaseM), .SpecialResM(SpecialResM), .QuotientM(QuotientM),
    .FlagsM(FlagsM), .WbReadyW(WbReadyW), .ResValidW(ResValidW), .ResultW(ResultW),
    .FlagsW(FlagsW), .LatencyW(LatencyW), .HoldFullE(HoldFullE)
  );

  fdivsqrt_result_hold #(.CNTW(4)) u_dut4 (
    .clk(clk), .reset(reset), .FlushM(FlushM), .StartE(StartE), .DoneE(DoneE),
    .SpecialCaseM(SpecialCaseM), .SpecialResM(SpecialResM), .QuotientM(QuotientM),
    .FlagsM(FlagsM), .WbReadyW(WbReadyW), .ResValidW(ResValidW4), .ResultW(ResultW4),
    .FlagsW(FlagsW4), .LatencyW(LatencyW4), .HoldFullE(HoldFullE4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; FlushM = 1'b0; StartE = 1'b0; DoneE = 1'b0; SpecialCaseM = 1'b0;
    SpecialResM = '0; QuotientM = '0; FlagsM = '0; WbReadyW = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (ResValidW !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ResValidW); end
    checks++; if (HoldFullE !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", HoldFullE); end
    checks++; if (ResultW !== 64'h0) begin errors++; $display("FAIL reset_result: got %h want 0", ResultW); end
    checks++; if (FlagsW !== 5'h0) begin errors++; $display("FAIL reset_flags: got %b want 0", FlagsW); end
    checks++; if (LatencyW !== 8'h0) begin errors++; $display("FAIL reset_latency: got %0d want 0", LatencyW); end
  endtask

  task automatic test_basic();
    StartE = 1'b1; step(); StartE = 1'b0;
    repeat (4) step();
    checks++; if (ResValidW !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %0b want 0", ResValidW); end
    DoneE = 1'b1; QuotientM = 64'h0123_4567_89AB_CDEF; SpecialResM = 64'hDEAD; FlagsM = 5'b00001;
    step(); DoneE = 1'b0;
    checks++; if (ResValidW !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", ResValidW); end
    checks++; if (HoldFullE !== 1'b1) begin errors++; $display("FAIL basic_full: got %0b want 1", HoldFullE); end
    checks++; if (ResultW !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL basic_result: got %h want 0123456789abcdef", ResultW); end
    checks++; if (FlagsW !== 5'b00001) begin errors++; $display("FAIL basic_flags: got %b want 00001", FlagsW); end
    checks++; if (LatencyW !== 8'd6) begin errors++; $display("FAIL basic_latency: got %0d want 6", LatencyW); end
    WbReadyW = 1'b1; step(); WbReadyW = 1'b0;
    checks++; if (ResValidW !== 1'b0) begin errors++; $display("FAIL basic_drain_valid: got %0b want 0", ResValidW); end
    checks++; if (HoldFullE !== 1'b0) begin errors++; $display("FAIL basic_drain_full: got %0b want 0", HoldFullE); end
  endtask

  task automatic test_done_held();
    StartE = 1'b1; step(); StartE = 1'b0;
    repeat (2) step();
    DoneE = 1'b1; QuotientM = 64'hAAAA_0000_0000_0001; FlagsM = 5'b00100;
    step();
    QuotientM = 64'hBBBB_0000_0000_0002; FlagsM = 5'b01000;
    for (int i = 0; i < 10; i++) begin
      DoneE = (i < 3);
      step();
      checks++; if (ResultW !== 64'hAAAA_0000_0000_0001) begin errors++; $display("FAIL held_result[%0d]: got %h want aaaa000000000001", i, ResultW); end
      checks++; if (HoldFullE !== 1'b1) begin errors++; $display("FAIL held_full[%0d]: got %0b want 1", i, HoldFullE); end
    end
    checks++; if (FlagsW !== 5'b00100) begin errors++; $display("FAIL held_flags: got %b want 00100", FlagsW); end
    checks++; if (LatencyW !== 8'd4) begin errors++; $display("FAIL held_latency: got %0d want 4", LatencyW); end
    WbReadyW = 1'b1; step(); WbReadyW = 1'b0;
    checks++; if (ResValidW !== 1'b0) begin errors++; $display("FAIL held_drain: got %0b want 0", ResValidW); end
  endtask

  task automatic test_special();
    StartE = 1'b1; step(); StartE = 1'b0;
    DoneE = 1'b1; SpecialCaseM = 1'b1; SpecialResM = 64'h7FF8_0000_0000_0000;
    QuotientM = 64'h1111_2222_3333_4444; FlagsM = 5'b10000;
    step(); DoneE = 1'b0; SpecialCaseM = 1'b0;
    checks++; if (ResultW !== 64'h7FF8_0000_0000_0000) begin errors++; $display("FAIL special_result: got %h want 7ff8000000000000", ResultW); end
    checks++; if (FlagsW !== 5'b10000) begin errors++; $display("FAIL special_flags: got %b want 10000", FlagsW); end
    checks++; if (LatencyW !== 8'd2) begin errors++; $display("FAIL special_latency: got %0d want 2", LatencyW); end
    WbReadyW = 1'b1; step(); WbReadyW = 1'b0;
  endtask

  task automatic test_flush();
    StartE = 1'b1; step(); StartE = 1'b0;
    DoneE = 1'b1; QuotientM = 64'h5555; FlagsM = 5'b00010;
    step(); DoneE = 1'b0;
    checks++; if (ResValidW !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %0b want 1", ResValidW); end
    FlushM = 1'b1; step(); FlushM = 1'b0;
    checks++; if (ResValidW !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", ResValidW); end
    checks++; if (HoldFullE !== 1'b0) begin errors++; $display("FAIL flush_full: got %0b want 0", HoldFullE); end
    // Flush coinciding with a done rise while empty: nothing is captured.
    FlushM = 1'b1; DoneE = 1'b1; step(); FlushM = 1'b0; DoneE = 1'b0;
    step();
    checks++; if (ResValidW !== 1'b0) begin errors++; $display("FAIL flush_done_valid: got %0b want 0", ResValidW); end
    StartE = 1'b1; step(); StartE = 1'b0;
    step();
    DoneE = 1'b1; QuotientM = 64'hC0FF_EE00_0000_0003; FlagsM = 5'b00011;
    step(); DoneE = 1'b0;
    checks++; if (ResValidW !== 1'b1) begin errors++; $display("FAIL flush_fresh_valid: got %0b want 1", ResValidW); end
    checks++; if (ResultW !== 64'hC0FF_EE00_0000_0003) begin errors++; $display("FAIL flush_fresh_result: got %h want c0ffee0000000003", ResultW); end
    checks++; if (LatencyW !== 8'd3) begin errors++; $display("FAIL flush_fresh_latency: got %0d want 3", LatencyW); end
  endtask

  task automatic test_back_to_back();
    // Entry state: FULL holding c0ffee...03
    StartE = 1'b1; step(); StartE = 1'b0;
    step();
    checks++; if (ResultW !== 64'hC0FF_EE00_0000_0003) begin errors++; $display("FAIL b2b_hold: got %h want c0ffee0000000003", ResultW); end
    DoneE = 1'b1; WbReadyW = 1'b1; QuotientM = 64'hD00D_0000_0000_0004; FlagsM = 5'b11000;
    step(); DoneE = 1'b0; WbReadyW = 1'b0;
    checks++; if (ResValidW !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b want 1", ResValidW); end
    checks++; if (ResultW !== 64'hD00D_0000_0000_0004) begin errors++; $display("FAIL b2b_result: got %h want d00d000000000004", ResultW); end
    checks++; if (FlagsW !== 5'b11000) begin errors++; $display("FAIL b2b_flags: got %b want 11000", FlagsW); end
    checks++; if (LatencyW !== 8'd3) begin errors++; $display("FAIL b2b_latency: got %0d want 3", LatencyW); end
    WbReadyW = 1'b1; step(); WbReadyW = 1'b0;
    checks++; if (ResValidW !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b want 0", ResValidW); end
  endtask

  task automatic test_start_done_same();
    StartE = 1'b1; step(); StartE = 1'b0;
    repeat (2) step();
    StartE = 1'b1; DoneE = 1'b1; QuotientM = 64'hE1; step(); StartE = 1'b0; DoneE = 1'b0;
    checks++; if (LatencyW !== 8'd4) begin errors++; $display("FAIL same_old_count: got %0d want 4", LatencyW); end
    WbReadyW = 1'b1; step(); WbReadyW = 1'b0;
    DoneE = 1'b1; QuotientM = 64'hE2; step(); DoneE = 1'b0;
    checks++; if (LatencyW !== 8'd3) begin errors++; $display("FAIL same_restart_count: got %0d want 3", LatencyW); end
    checks++; if (ResultW !== 64'hE2) begin errors++; $display("FAIL same_result: got %h want e2", ResultW); end
    WbReadyW = 1'b1; step(); WbReadyW = 1'b0;
  endtask

  task automatic test_saturation_and_reset();
    StartE = 1'b1; step(); StartE = 1'b0;
    repeat (19) step();
    DoneE = 1'b1; QuotientM = 64'hF00; FlagsM = 5'b00101; step(); DoneE = 1'b0;
    checks++; if (LatencyW !== 8'd21) begin errors++; $display("FAIL sat_latency8: got %0d want 21", LatencyW); end
    checks++; if (LatencyW4 !== 4'd15) begin errors++; $display("FAIL sat_latency4: got %0d want 15", LatencyW4); end
    checks++; if (ResValidW4 !== 1'b1) begin errors++; $display("FAIL sat_valid4: got %0b want 1", ResValidW4); end
    // Reset while FULL and with a new op running.
    StartE = 1'b1; step(); StartE = 1'b0;
    repeat (2) step();
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (ResValidW !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", ResValidW); end
    checks++; if (HoldFullE !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b want 0", HoldFullE); end
    checks++; if (ResultW !== 64'h0) begin errors++; $display("FAIL rst_result: got %h want 0", ResultW); end
    checks++; if (FlagsW !== 5'h0) begin errors++; $display("FAIL rst_flags: got %b want 0", FlagsW); end
    checks++; if (LatencyW !== 8'h0) begin errors++; $display("FAIL rst_latency: got %0d want 0", LatencyW); end
    checks++; if (ResValidW4 !== 1'b0) begin errors++; $display("FAIL rst_valid4: got %0b want 0", ResValidW4); end
    checks++; if (LatencyW4 !== 4'h0) begin errors++; $display("FAIL rst_latency4: got %0d want 0", LatencyW4); end
    checks++; if (ResultW4 !== 64'h0) begin errors++; $display("FAIL rst_result4: got %h want 0", ResultW4); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_held();
    test_special();
    test_flush();
    test_back_to_back();
    test_start_done_same();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
